// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types, defaults and baud divisor helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int unsigned SAMPLE_RATE_DEFAULT = 16;
    localparam int unsigned DIV_WIDTH_DEFAULT   = 16;
    localparam int unsigned FRAC_BITS_DEFAULT   = 8;

    typedef logic [DIV_WIDTH_DEFAULT+FRAC_BITS_DEFAULT-1:0] baud_div_t;

    // Rounded fixed-point clock periods per oversample tick.
    function automatic logic [63:0] calc_baud_div(
        input logic [63:0] clk_hz,
        input logic [63:0] baud_hz,
        input logic [63:0] sample_rate,
        input int unsigned frac_bits
    );
        logic [63:0] num;
        logic [63:0] den;
        num = clk_hz << frac_bits;
        den = baud_hz * sample_rate;
        return (num + (den >> 1)) / den;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_phase_counter.sv
// ============================================================================
// Module      : uart_phase_counter
// Description : Sample-index counter with mid-bit and end-of-bit strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_phase_counter
    import uart_pkg::*;
#(
    parameter int unsigned SAMPLE_RATE = SAMPLE_RATE_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick,
    input  logic                           clear,
    output logic [$clog2(SAMPLE_RATE)-1:0] idx,
    output logic                           mid_tick,
    output logic                           bit_tick
);

    localparam int unsigned          c_idx_w = $clog2(SAMPLE_RATE);
    localparam logic [c_idx_w-1:0]   c_mid   = c_idx_w'(SAMPLE_RATE/2 - 1);
    localparam logic [c_idx_w-1:0]   c_last  = c_idx_w'(SAMPLE_RATE - 1);

    // Strobes decode the index before it advances; wrap is free since SAMPLE_RATE is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx      <= '0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            mid_tick <= tick && (idx == c_mid);
            bit_tick <= tick && (idx == c_last);
            if (tick) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_baud_generator.sv
// ============================================================================
// Module      : uart_baud_generator
// Description : Programmable fractional baud tick generator with RX mid-bit
//               and TX bit strobes. Macro UART_BAUD_FRAC_EN selects the
//               fractional accumulator; otherwise an integer counter is used.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_generator
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned DEFAULT_BAUD_HZ = 115_200,
    parameter int unsigned SAMPLE_RATE     = SAMPLE_RATE_DEFAULT,
    parameter int unsigned DIV_WIDTH       = 16,
    parameter int unsigned FRAC_BITS       = 8
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           enable_in,
    input  logic                           clear_in,
    input  logic [DIV_WIDTH+FRAC_BITS-1:0] div_in,
    input  logic                           div_load_in,
    output logic                           div_pending_out,
    output logic                           tick_out,
    output logic                           mid_tick_out,
    output logic                           bit_tick_out,
    output logic [$clog2(SAMPLE_RATE)-1:0] sample_idx_out
);

    localparam int unsigned     c_dw          = DIV_WIDTH + FRAC_BITS;
    localparam logic [63:0]     c_div_calc    = calc_baud_div(64'(CLK_HZ), 64'(DEFAULT_BAUD_HZ),
                                                              64'(SAMPLE_RATE), FRAC_BITS);
    localparam logic [c_dw-1:0] c_div_rounded = c_div_calc[c_dw-1:0];
    localparam logic [c_dw-1:0] c_one         = c_dw'(1) << FRAC_BITS;

    logic [c_dw-1:0] r_div_active;
    logic [c_dw-1:0] r_div_pend_val;
    logic            r_div_pend;
    logic            r_tick;
    logic [c_dw-1:0] w_div_capture;
    logic            w_tick;
    logic            w_tick_gen;
    logic            w_hold;

    assign w_hold     = !enable_in || clear_in;
    assign w_tick_gen = !w_hold && w_tick;

`ifdef UART_BAUD_FRAC_EN
    localparam logic [c_dw-1:0] c_default_div = c_div_rounded;

    logic [c_dw:0]   r_acc;
    logic [c_dw:0]   w_sum;
    logic [c_dw-1:0] w_div_eff;

    // The extra accumulator bit absorbs acc+ONE, which stays below div_eff+ONE.
    assign w_div_eff     = (r_div_active < c_one) ? c_one : r_div_active;
    assign w_sum         = r_acc + {1'b0, c_one};
    assign w_tick        = (w_sum >= {1'b0, w_div_eff});
    assign w_div_capture = div_in;

    always_ff @(posedge clk_in) begin
        if (rst_in || w_hold) begin
            r_acc <= '0;
        end else if (w_tick) begin
            r_acc <= w_sum - {1'b0, w_div_eff};
        end else begin
            r_acc <= w_sum;
        end
    end
`else
    localparam logic [c_dw-1:0] c_int_mask    = {{DIV_WIDTH{1'b1}}, {FRAC_BITS{1'b0}}};
    localparam logic [c_dw-1:0] c_default_div = c_div_rounded & c_int_mask;

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] w_period;

    assign w_period      = (r_div_active < c_one) ? DIV_WIDTH'(1) : r_div_active[c_dw-1:FRAC_BITS];
    assign w_tick        = ((r_cnt + DIV_WIDTH'(1)) >= w_period);
    assign w_div_capture = div_in & c_int_mask;

    always_ff @(posedge clk_in) begin
        if (rst_in || w_hold || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
        end
    end
`endif

    // A load in the same cycle as a transfer wins the pending register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_div_active   <= c_default_div;
            r_div_pend_val <= '0;
            r_div_pend     <= 1'b0;
            r_tick         <= 1'b0;
        end else begin
            r_tick <= w_tick_gen;
            if (r_div_pend && (w_tick_gen || w_hold)) begin
                r_div_active <= r_div_pend_val;
                r_div_pend   <= 1'b0;
            end
            if (div_load_in) begin
                r_div_pend_val <= w_div_capture;
                r_div_pend     <= 1'b1;
            end
        end
    end

    assign div_pending_out = r_div_pend;
    assign tick_out        = r_tick;

    uart_phase_counter #(
        .SAMPLE_RATE (SAMPLE_RATE)
    ) u_phase_counter (
        .clk      (clk_in),
        .rst      (rst_in),
        .tick     (w_tick_gen),
        .clear    (w_hold),
        .idx      (sample_idx_out),
        .mid_tick (mid_tick_out),
        .bit_tick (bit_tick_out)
    );

endmodule

`default_nettype wire
